// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcode prefixes, ALU encodings and controller enums
package legv8_pkg;

  localparam logic [5:0]  OP_B_PFX    = 6'b000101;
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_PFX = 8'b10110101;
  localparam logic [9:0]  OP_ADDI_PFX = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI_PFX = 10'b1101000100;
  localparam logic [10:0] OP_AND      = 11'b10001010000;
  localparam logic [10:0] OP_ADD      = 11'b10001011000;
  localparam logic [10:0] OP_ORR      = 11'b10101010000;
  localparam logic [10:0] OP_SUB      = 11'b11001011000;
  localparam logic [10:0] OP_STUR     = 11'b11111000000;
  localparam logic [10:0] OP_LDUR     = 11'b11111000010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CBZ  = 4'b0111;
  localparam logic [3:0] ALU_B    = 4'b1000;
  localparam logic [3:0] ALU_CBNZ = 4'b1001;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;

  typedef enum logic [2:0] {RTYPE, ITYPE, LOAD, STORE, BR, CBZ, CBNZ, ILLEGAL} iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic       reg2loc;
    logic       alusrc;
    logic [3:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational LEGv8 opcode to class and static controls
module opcode_decoder (
  input  logic [10:0] opCode,
  output logic [2:0]  cls,
  output logic        reg2loc,
  output logic        alusrc,
  output logic [3:0]  aluop
);
  import legv8_pkg::*;

  iclass_t cls_c;

  // Prefix matches are checked first so their don't-care low bits never reach the full compare.
  always_comb begin
    cls_c   = ILLEGAL;
    reg2loc = 1'b0;
    alusrc  = 1'b0;
    aluop   = ALU_AND;
    if (opCode[10:5] == OP_B_PFX) begin
      cls_c   = BR;
      reg2loc = 1'b1;
      aluop   = ALU_B;
    end else if (opCode[10:3] == OP_CBZ_PFX) begin
      cls_c   = CBZ;
      reg2loc = 1'b1;
      aluop   = ALU_CBZ;
    end else if (opCode[10:3] == OP_CBNZ_PFX) begin
      cls_c   = CBNZ;
      reg2loc = 1'b1;
      aluop   = ALU_CBNZ;
    end else if (opCode[10:1] == OP_ADDI_PFX) begin
      cls_c  = ITYPE;
      alusrc = 1'b1;
      aluop  = ALU_ADD;
    end else if (opCode[10:1] == OP_SUBI_PFX) begin
      cls_c  = ITYPE;
      alusrc = 1'b1;
      aluop  = ALU_SUB;
    end else begin
      case (opCode)
        OP_AND: cls_c = RTYPE;
        OP_ADD: begin
          cls_c = RTYPE;
          aluop = ALU_ADD;
        end
        OP_ORR: begin
          cls_c = RTYPE;
          aluop = ALU_ORR;
        end
        OP_SUB: begin
          cls_c = RTYPE;
          aluop = ALU_SUB;
        end
        OP_STUR: begin
          cls_c   = STORE;
          reg2loc = 1'b1;
          alusrc  = 1'b1;
          aluop   = ALU_ADD;
        end
        OP_LDUR: begin
          cls_c  = LOAD;
          alusrc = 1'b1;
          aluop  = ALU_ADD;
        end
        default: cls_c = ILLEGAL;
      endcase
    end
  end

  assign cls = cls_c;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - LEGv8 multicycle FSM with memory wait/timeout handling
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        opCode,
  input  logic               aluZero,
  input  logic               instrReady,
  input  logic               memReady,
  output logic               instrReq,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               pcSrc,
  output logic               reg2Loc,
  output logic               aluSrc,
  output logic               memToReg,
  output logic               memRead,
  output logic               memWrite,
  output logic               regWrite,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);
  import legv8_pkg::*;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [2:0] dec_cls;
  logic       dec_reg2loc;
  logic       dec_alusrc;
  logic [3:0] dec_aluop;

  logic instr_req, ir_write, pc_write, pc_src, mem_read, mem_write;
  logic reg_write, mem_to_reg, flt, stat_en, wait_hit, taken;

  opcode_decoder u_dec (
    .opCode  (opCode),
    .cls     (dec_cls),
    .reg2loc (dec_reg2loc),
    .alusrc  (dec_alusrc),
    .aluop   (dec_aluop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      ctrl_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // wait_d defaults to zero so every entry into FETCH or MEM starts a fresh count.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    wait_d     = '0;
    retired_d  = retired_q;
    instr_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    flt        = 1'b0;
    stat_en    = 1'b0;
    wait_hit   = TIMEOUT_EN && (wait_q == WAIT_LAST);
    taken      = (ctrl_q.cls == BR) || ((ctrl_q.cls == CBZ) && aluZero) ||
                 ((ctrl_q.cls == CBNZ) && !aluZero);
    case (state_q)
      FETCH: begin
        instr_req = 1'b1;
        if (instrReady) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (wait_hit) begin
          state_d = FAULT;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        ctrl_d.cls     = iclass_t'(dec_cls);
        ctrl_d.reg2loc = dec_reg2loc;
        ctrl_d.alusrc  = dec_alusrc;
        ctrl_d.aluop   = dec_aluop;
        state_d = (iclass_t'(dec_cls) == ILLEGAL) ? FAULT : EXEC;
      end
      EXEC: begin
        stat_en = 1'b1;
        case (ctrl_q.cls)
          BR, CBZ, CBNZ: begin
            pc_write = 1'b1;
            pc_src   = taken;
            state_d  = FETCH;
          end
          LOAD, STORE: state_d = MEM;
          default:     state_d = WB;
        endcase
      end
      MEM: begin
        stat_en   = 1'b1;
        mem_read  = (ctrl_q.cls == LOAD);
        mem_write = (ctrl_q.cls == STORE);
        if (memReady) begin
          if (ctrl_q.cls == LOAD) begin
            state_d = WB;
          end else begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        end else if (wait_hit) begin
          state_d = FAULT;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WB: begin
        stat_en    = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (ctrl_q.cls == LOAD);
        pc_write   = 1'b1;
        state_d    = FETCH;
      end
      FAULT:   flt = 1'b1;
      default: state_d = FAULT;
    endcase
    if (pc_write) retired_d = retired_q + CNT_W'(1);
  end

  // Gating with rst keeps FETCH's request low while reset is held.
  assign instrReq = instr_req & ~rst;
  assign irWrite  = ir_write & ~rst;
  assign pcWrite  = pc_write & ~rst;
  assign pcSrc    = pc_src & ~rst;
  assign reg2Loc  = stat_en & ctrl_q.reg2loc & ~rst;
  assign aluSrc   = stat_en & ctrl_q.alusrc & ~rst;
  assign memToReg = mem_to_reg & ~rst;
  assign memRead  = mem_read & ~rst;
  assign memWrite = mem_write & ~rst;
  assign regWrite = reg_write & ~rst;
  assign fault    = flt & ~rst;
  assign aluOp    = (stat_en && !rst) ? ALUOP_W'(ctrl_q.aluop) : '0;
  assign retired  = retired_q;

endmodule
